// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the memory responder
// Purpose: FSM state encoding, the maximum legal wait latency and the wait
//   counter width derived from it.
// Ports: none (package).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int MEM_RESP_LAT_MAX = 15;
  localparam int MEM_RESP_CNT_W   = $clog2(MEM_RESP_LAT_MAX + 1);

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH_WORDS x 32 unified instruction/data store
// Purpose: word storage with one synchronous byte-strobed write port, one
//   asynchronous read port and, when MEM_RESP_LOAD_PORT_EN is defined, a
//   whole-word load port that takes priority over the strobed port.
// Ports:
//   clk            in   clock
//   we             in   strobed write enable
//   waddr/raddr    in   word index for write / read
//   wdata, wstrb   in   write data and byte-lane enables
//   rdata          out  asynchronous read of mem[raddr]
//   ld_en/ld_addr/ld_data  in  preload port (MEM_RESP_LOAD_PORT_EN only)
// Storage is never reset.
module mem_resp_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
`ifdef MEM_RESP_LOAD_PORT_EN
  ,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data
`endif
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
`ifdef MEM_RESP_LOAD_PORT_EN
    // Issued last so it overrides any strobed lanes hitting the same word.
    if (ld_en) mem_q[ld_addr] <= ld_data;
`endif
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with programmable wait
// Purpose: accepts one valid/ready request at a time, performs a byte-strobed
//   write or word read on mem_resp_array at the accept edge, and presents the
//   response LATENCY cycles later, held until rsp_ready.
// Parameters: DEPTH_WORDS (words of storage), LATENCY (1..15).
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = FSM idle)
//   req_write, req_addr, req_wdata, req_wstrb   request payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    read word (0 on write/error), error flag
//   ld_en, ld_addr, ld_data  preload port, present with MEM_RESP_LOAD_PORT_EN
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int LATENCY     = 1,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err
`ifdef MEM_RESP_LOAD_PORT_EN
  ,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data
`endif
);

  localparam logic [MEM_RESP_CNT_W-1:0] CNT_LOAD = MEM_RESP_CNT_W'(LATENCY - 1);
  localparam logic [MEM_RESP_CNT_W-1:0] CNT_ONE  = MEM_RESP_CNT_W'(1);

  state_e                    state_q;
  logic [MEM_RESP_CNT_W-1:0] cnt_q;
  logic                      rsp_valid_q;
  logic [31:0]               rdata_q;
  logic                      err_q;

  logic                      addr_err;
  logic                      accept;
  logic [IDX_W-1:0]          idx;
  logic [31:0]               rd_word;

  // Range compare uses the whole word address so high address bits never alias.
  assign addr_err  = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready && !reset;
  assign idx       = req_addr[IDX_W+1:2];

  mem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (accept && req_write && !addr_err),
    .waddr (idx),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .raddr (idx),
    .rdata (rd_word)
`ifdef MEM_RESP_LOAD_PORT_EN
    ,
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            err_q   <= addr_err;
            rdata_q <= (req_write || addr_err) ? 32'h0 : rd_word;
            if (LATENCY == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Purpose: drives two responders (LATENCY 1 and 4) against a word-array
//   reference model; covers MEM_RESP_LOAD_PORT_EN when that macro is defined.
// Ports: none (top-level bench).
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 1;
  localparam int LAT1  = 4;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
`ifdef MEM_RESP_LOAD_PORT_EN
  logic        ld_en     [2];
  logic [7:0]  ld_addr   [2];
  logic [31:0] ld_data   [2];
`endif

  logic [31:0] model [2][DEPTH];
  int          lat_of [2];
  int          n_tests;
  int          n_fail;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef MEM_RESP_LOAD_PORT_EN
    , .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
`endif
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef MEM_RESP_LOAD_PORT_EN
    , .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; expectations come from the word-array model.
  task automatic txn(input int u, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws, input int hold);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] held;
    int          idx;
    int          lat;
    exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    exp_rd  = 32'h0;
    idx     = int'(addr >> 2);
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) model[u][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = model[u][idx];
      end
    end
    check_eq("req_ready_idle", 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    req_wstrb[u] = ws;
    cyc();
    req_valid[u] = 1'b0;
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin
      check_eq("req_ready_wait", 32'(req_ready[u]), 32'd0);
      cyc();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(lat_of[u]));
    check_eq("rsp_rdata", rsp_rdata[u], exp_rd);
    check_eq("rsp_err", 32'(rsp_err[u]), 32'(exp_err));
    held = rsp_rdata[u];
    // A stray write while the response is pending must be ignored.
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'b1;
      req_write[u] = 1'b1;
      req_addr[u]  = 32'h40;
      req_wdata[u] = ~model[u][16];
      req_wstrb[u] = 4'hF;
      cyc();
      check_eq("rsp_valid_hold", 32'(rsp_valid[u]), 32'd1);
      check_eq("rdata_stable", rsp_rdata[u], held);
      check_eq("req_ready_resp", 32'(req_ready[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    cyc();
    rsp_ready[u] = 1'b0;
    check_eq("rsp_valid_done", 32'(rsp_valid[u]), 32'd0);
    check_eq("req_ready_done", 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    int          u;
    int          kind;
    logic        wr;
    logic [31:0] addr;
    n_tests   = 0;
    n_fail    = 0;
    lat_of[0] = LAT0;
    lat_of[1] = LAT1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_wstrb[k] = 4'h0; rsp_ready[k] = 1'b0;
`ifdef MEM_RESP_LOAD_PORT_EN
      ld_en[k] = 1'b0; ld_addr[k] = 8'h0; ld_data[k] = 32'h0;
`endif
    end
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check_eq("reset_rsp_rdata", rsp_rdata[k], 32'h0);
      check_eq("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
      check_eq("reset_req_ready", 32'(req_ready[k]), 32'd1);
      rst[k] = 1'b0;
    end
    cyc();

    // Fill every word so the model knows all contents.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        txn(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    // Directed: full write/read, byte strobes, empty strobe.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Directed: latency 4 with a held response and ignored stray requests.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 3);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0);

    // Directed: errors, including an out-of-range address that would alias word 0.
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1, 1'b1, 32'h8000_0000, 32'h12345678, 4'hF, 1);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      u    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 32'(4 * DEPTH + $urandom_range(0, 1000) * 4);
      else if (kind == 2) addr = 32'h8000_0000 | ($urandom & 32'hFFFF_FFFC);
      else                addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      txn(u, wr, addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    // Reset during WAIT: transaction dropped, accepted write kept.
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h80;
    req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'hF;
    cyc();
    model[1][32] = 32'hCAFEF00D;
    req_valid[1] = 1'b0;
    cyc();
    #2 rst[1] = 1'b1;
    #1;
    check_eq("rst_wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check_eq("rst_wait_req_ready", 32'(req_ready[1]), 32'd1);
    cyc();
    cyc();
    check_eq("rst_wait_still_idle", 32'(rsp_valid[1]), 32'd0);
    rst[1] = 1'b0;
    cyc();
    txn(1, 1'b0, 32'h80, 32'h0, 4'h0, 0);

    // Reset during RESP: rsp_valid drops without a clock edge.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h20;
    cyc();
    req_valid[0] = 1'b0;
    check_eq("pre_rst_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    #2 rst[0] = 1'b1;
    #1;
    check_eq("rst_resp_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_eq("rst_resp_rdata", rsp_rdata[0], 32'h0);
    cyc();
    rst[0] = 1'b0;
    cyc();
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

`ifdef MEM_RESP_LOAD_PORT_EN
    // Preload words 0 and 1; the load to word 1 collides with a write request.
    ld_en[0] = 1'b1; ld_addr[0] = 8'd0; ld_data[0] = 32'h002081B3;
    cyc();
    ld_addr[0] = 8'd1; ld_data[0] = 32'h00208463;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h4;
    req_wdata[0] = 32'h12345678; req_wstrb[0] = 4'hF;
    cyc();
    ld_en[0] = 1'b0;
    req_valid[0] = 1'b0;
    model[0][0] = 32'h002081B3;
    model[0][1] = 32'h00208463;
    check_eq("ld_write_rsp_err", 32'(rsp_err[0]), 32'd0);
    rsp_ready[0] = 1'b1;
    cyc();
    rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
